// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the canonical NOP word and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// pc_reg: WIDTH-bit program-counter register with load enable and
// asynchronous active-high reset to RESET_PC.
//   CLK, RST   clock / async reset
//   en_i       load d_i on the rising edge
//   d_i        next PC value
//   q_o        current PC
module pc_reg #(
  parameter int unsigned       WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q <= RESET_PC;
    end else if (en_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps at most one
// instruction-memory request outstanding, and presents InstrF/PCF/PCPlus4F.
//   CLK, RST             clock / async active-high reset
//   StallF               hold the current fetch
//   PCSrcE, PCTargetE    execute-stage redirect (target bits [1:0] ignored)
//   IMemReq, IMemAddr    memory request (address stable until IMemValid)
//   IMemValid, IMemRData memory response
//   InstrF, PCF, PCPlus4F, ValidF  outputs to the fetch->decode register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(FETCH_RESET_PC)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             StallF,
  input  logic             PCSrcE,
  input  logic [WIDTH-1:0] PCTargetE,
  output logic             IMemReq,
  output logic [WIDTH-1:0] IMemAddr,
  input  logic             IMemValid,
  input  logic [WIDTH-1:0] IMemRData,
  output logic [WIDTH-1:0] InstrF,
  output logic [WIDTH-1:0] PCF,
  output logic [WIDTH-1:0] PCPlus4F,
  output logic             ValidF
);

  localparam logic [WIDTH-1:0] NOP = WIDTH'(NOP_INSTR);

  fetch_state_t     state_q;
  logic [WIDTH-1:0] buf_q;
  logic [WIDTH-1:0] tgt_q;
  // Low for the cycle between reset release and the first clock edge, so the
  // first request appears in the first full cycle after reset.
  logic             active_q;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] tgt_in;
  logic             pc_en;
  logic [WIDTH-1:0] pc_d;

  assign tgt_in   = {PCTargetE[WIDTH-1:2], 2'b00};
  assign pc_plus4 = pc_q + WIDTH'(4);

  pc_reg #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (pc_en),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  assign IMemReq  = active_q && (state_q != HOLD);
  assign IMemAddr = pc_q;
  assign PCF      = pc_q;
  assign PCPlus4F = pc_plus4;

  // Output muxes and next-PC selection.
  always_comb begin
    ValidF = 1'b0;
    InstrF = NOP;
    pc_en  = 1'b0;
    pc_d   = pc_q;
    unique case (state_q)
      FETCH: begin
        if (IMemReq && IMemValid) begin
          if (PCSrcE) begin
            pc_en = 1'b1;
            pc_d  = tgt_in;
          end else begin
            ValidF = 1'b1;
            InstrF = IMemRData;
            if (!StallF) begin
              pc_en = 1'b1;
              pc_d  = pc_plus4;
            end
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pc_en = 1'b1;
          pc_d  = tgt_in;
        end else begin
          ValidF = 1'b1;
          InstrF = buf_q;
          if (!StallF) begin
            pc_en = 1'b1;
            pc_d  = pc_plus4;
          end
        end
      end
      DROP: begin
        // Stale response is discarded; a same-cycle redirect beats the saved one.
        if (IMemValid) begin
          pc_en = 1'b1;
          pc_d  = PCSrcE ? tgt_in : tgt_q;
        end
      end
      default: begin
        ValidF = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= FETCH;
      buf_q    <= NOP;
      tgt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
      unique case (state_q)
        FETCH: begin
          if (active_q) begin
            if (IMemValid) begin
              if (!PCSrcE && StallF) begin
                buf_q   <= IMemRData;
                state_q <= HOLD;
              end
            end else if (PCSrcE) begin
              tgt_q   <= tgt_in;
              state_q <= DROP;
            end
          end
        end
        HOLD: begin
          if (PCSrcE || !StallF) begin
            state_q <= FETCH;
          end
        end
        DROP: begin
          if (IMemValid) begin
            state_q <= FETCH;
          end else if (PCSrcE) begin
            tgt_q <= tgt_in;
          end
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined RISC-V core: owns the program counter, issues one instruction-memory request at a time, and presents `InstrF`/`PCF`/`PCPlus4F` to the fetch→decode pipeline register.
- Honours hazard-unit stalls and execute-stage branch/jump redirects.
- Tolerates a variable-latency instruction memory, so fetch can be pointed at a cache or slow ROM without touching the downstream pipeline.

## Interface
- `WIDTH`, 32, data/address width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CLK`  in  1  clock; all state updates on rising edge
- `RST`  in  1  asynchronous, active-high reset
- `StallF`  in  1  hazard unit: hold current fetch
- `PCSrcE`  in  1  execute stage: redirect taken
- `PCTargetE`  in  WIDTH  redirect target; bits [1:0] forced to 0
- `IMemReq`  out  1  request valid
- `IMemAddr`  out  WIDTH  request address
- `IMemValid`  in  1  response data valid this cycle; may be high in the same cycle `IMemReq` is first raised (zero wait)
- `IMemRData`  in  WIDTH  response instruction
- `InstrF`  out  WIDTH  instruction for `PCF`; NOP (32'h0000_0013) when `ValidF`=0
- `PCF`  out  WIDTH  address of `InstrF`
- `PCPlus4F`  out  WIDTH  `PCF`+4, modulo 2^WIDTH
- `ValidF`  out  1  `InstrF` is a real, right-path instruction

## Operation
- **Memory protocol**
  - One request outstanding at most.
  - While `IMemReq`=1, `IMemAddr` holds stable until the cycle `IMemValid`=1.
  - `IMemValid` while `IMemReq`=0 is ignored.
- **Priority:** `PCSrcE` > `StallF` > normal advance.
- **FSM states**
  - FETCH (reset state)
    - Outputs: `IMemReq`=1, `IMemAddr`=PC.
    - `IMemValid`=1, no redirect: `InstrF`=`IMemRData` (combinational pass-through), `ValidF`=1.
      - `StallF`=0: PC←PC+4, stay FETCH.
      - `StallF`=1: latch `IMemRData` into the instruction buffer, go HOLD.
    - `IMemValid`=1 and `PCSrcE`=1: `ValidF`=0, `InstrF`=NOP, PC←`PCTargetE`, stay FETCH.
    - `IMemValid`=0: `ValidF`=0, `InstrF`=NOP, PC holds.
      - If `PCSrcE`=1: save `PCTargetE` into the target register, go DROP.
  - HOLD
    - Outputs: `IMemReq`=0, `InstrF`=buffer, `ValidF`=1.
    - `PCSrcE`=1: `ValidF`=0, PC←`PCTargetE`, go FETCH.
    - Else `StallF`=0: PC←PC+4, go FETCH.
    - Else stay HOLD.
  - DROP (stale request in flight)
    - Outputs: `IMemReq`=1, `IMemAddr`=old PC held, `ValidF`=0, `InstrF`=NOP.
    - `PCSrcE`=1: overwrite the saved target.
    - `IMemValid`=1: discard data, PC←saved target, or ←`PCTargetE` if `PCSrcE` is asserted that cycle; go FETCH.
    - `StallF` has no effect in DROP.
- `PCF` is always the PC register, including in DROP (old PC).
- PC arithmetic wraps silently at 2^WIDTH.

## Timing
- **Reset (async, while `RST`=1)**
  - PC=`RESET_PC`, state=FETCH, buffer=NOP, saved target=0.
  - `IMemReq`=0, `ValidF`=0, `InstrF`=NOP, `PCF`=`RESET_PC`, `PCPlus4F`=`RESET_PC`+4.
- First request is raised in the first cycle after `RST` deasserts.
- **Zero-wait memory:** one instruction per cycle; `InstrF` valid in the same cycle as the request.
- **N-wait memory:** `ValidF` low for N cycles per instruction.
- **Redirect penalty:** the target is requested in the cycle after `PCSrcE` in FETCH/HOLD. In DROP the target is requested after the stale response returns.
- **Reset mid-request:** the outstanding request is abandoned. The memory must be reset by the same `RST`.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH, HOLD, DROP}
  - `NOP_INSTR` = 32'h0000_0013
  - `RESET_PC` default
- One sub-module is natural: `pc_reg`, a WIDTH-bit register with enable, load value and async active-high reset to `RESET_PC`.
- The FSM, instruction buffer, target register and output muxes live in `fetch_unit`.

## Test plan
- **Zero-wait memory, no stalls:** `IMemValid`=1 every cycle after reset → `PCF` = 0, 4, 8, 12 on consecutive cycles, `ValidF`=1, `InstrF` matches memory contents.
- **2-wait memory:** `IMemValid` on every 3rd cycle → `IMemAddr` stable across the wait cycles, `ValidF` pulses once per 3 cycles, PC steps by 4.
- **`StallF`=1 for 3 cycles as `IMemValid` returns word 0x00A00093 at PC 0x8** → HOLD; `InstrF`=0x00A00093 and `ValidF`=1 for all 3 cycles; `IMemReq`=0; PC then advances to 0xC.
- **`PCSrcE`=1, target 0x40, while waiting at PC 0x10 (2-wait)** → DROP; `IMemAddr` stays 0x10 until `IMemValid`; data discarded with `ValidF`=0; next request is at 0x40.
- **`PCSrcE` and `StallF` in the same cycle with `IMemValid`=1** → `ValidF`=0, PC=`PCTargetE` next cycle, no HOLD entry.
- **`RST` asserted asynchronously mid-request at PC 0x24** → outputs reach their reset values before the next clock edge; fetch restarts at `RESET_PC`.
